// File: rtl/updown_mod_counter.sv
// updown_mod_counter: prescaled up/down counter over the range 0..limit.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   PRESCALE enabled cycles per count step (1..256)
//   SATURATE 0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       count enable; the prescaler only advances while en=1
//   up       direction: 1 = increment, 0 = decrement
//   clear    synchronous clear (highest priority)
//   load     synchronous load of min(load_val, limit)
//   load_val value captured on load
//   limit    inclusive upper bound of the count range
//   count    registered counter value
//   tc       registered one-cycle terminal-count pulse
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // A one-bit prescaler is kept even for PRESCALE=1; it then stays at 0 and
  // every enabled edge is a tick.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc, psc_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             tick;

  assign tick = en && (psc == PSC_LAST);

  always_comb begin
    count_nxt = count;
    psc_nxt   = psc;
    tc_nxt    = 1'b0;
    if (clear) begin
      count_nxt = '0;
      psc_nxt   = '0;
    end else if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
      psc_nxt   = '0;
    end else if (en) begin
      psc_nxt = tick ? '0 : psc + PW'(1);
      if (tick) begin
        if (up) begin
          if (count < limit) begin
            count_nxt = count + WIDTH'(1);
          end else begin
            // Boundary reached (or count above a lowered limit).
            count_nxt = (SATURATE != 0) ? limit : '0;
            tc_nxt    = 1'b1;
          end
        end else begin
          if (count > limit) begin
            // Limit was lowered under us: snap into range, no pulse.
            count_nxt = limit;
          end else if (count == '0) begin
            count_nxt = (SATURATE != 0) ? '0 : limit;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      psc   <= psc_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule
